// File: rtl/div_ctrl.sv
// div_ctrl: 32-iteration restoring divide sequencer for DIV/DIVU with pipeline stall request.
// Signed operation is compiled in only when DIV_SIGNED_EN is defined; otherwise all divides are unsigned.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        annul,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall_req
);
  typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] dvs_q, dvs_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic [64:0] sh;
  logic [32:0] diff;
  logic [63:0] step;
  logic [31:0] op1_abs, op2_abs, quo_fix, rem_fix;
  logic        accept;
  // One shared subtractor: trial-subtract the divisor from the shifted partial remainder.
  assign sh     = {work_q, 1'b0};
  assign diff   = sh[64:32] - {1'b0, dvs_q};
  assign step   = diff[32] ? sh[63:0] : {diff[31:0], sh[31:1], 1'b1};
  assign accept = (state_q == IDLE) && start && !annul && (opdata2 != 32'd0);
`ifdef DIV_SIGNED_EN
  logic s1, s2, negq_q, negr_q;
  assign s1      = signed_div & opdata1[31];
  assign s2      = signed_div & opdata2[31];
  assign op1_abs = s1 ? ~opdata1 + 32'd1 : opdata1;
  assign op2_abs = s2 ? ~opdata2 + 32'd1 : opdata2;
  assign quo_fix = negq_q ? ~step[31:0] + 32'd1 : step[31:0];
  assign rem_fix = negr_q ? ~step[63:32] + 32'd1 : step[63:32];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (accept) begin
      negq_q <= s1 ^ s2;
      negr_q <= s1;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = signed_div;
  assign op1_abs = opdata1;
  assign op2_abs = opdata2;
  assign quo_fix = step[31:0];
  assign rem_fix = step[63:32];
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      work_q   <= 64'd0;
      dvs_q    <= 32'd0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    ready_d  = ready_q;
    unique case (state_q)
      IDLE: begin
        ready_d  = 1'b0;
        result_d = 64'd0;
        if (start && !annul) begin
          if (opdata2 == 32'd0) state_d = ZERO;
          else begin
            state_d = BUSY;
            work_d  = {32'd0, op1_abs};
            dvs_d   = op2_abs;
            cnt_d   = 5'd0;
          end
        end
      end
      ZERO: begin
        state_d = (annul || !start) ? IDLE : DONE;
        ready_d = !(annul || !start);
      end
      BUSY: begin
        if (annul || !start) state_d = IDLE;
        else begin
          work_d = step;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      DONE: begin
        if (annul || !start) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign result    = result_q;
  assign ready     = ready_q;
  assign stall_req = ((state_q == IDLE) && start && !annul) || (state_q == ZERO) || (state_q == BUSY);
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: table-driven checks of div_ctrl plus annul, async-reset and handshake sequences.
module tb_div_ctrl;
  logic        clk, rst, start, annul, signed_div;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  logic        ready, stall_req;
  int n_cmp = 0, n_fail = 0;

  div_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .annul(annul), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .result(result), .ready(ready), .stall_req(stall_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sd;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; issues a divide and follows it through DONE and the start-drop.
  task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b, input logic sd,
                         input logic [63:0] exp, input int lat, input int hold);
    int  n;
    bit  stall_ok;
    opdata1 = a; opdata2 = b; signed_div = sd; start = 1'b1;
    n = 0; stall_ok = 1'b1;
    #1;
    while (!ready && n < 40) begin
      if (!stall_req) stall_ok = 1'b0;
      cyc();
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(lat));
    chk({nm, " result"}, result, exp);
    chk({nm, " stall before done"}, {63'd0, stall_ok}, 64'd1);
    chk({nm, " stall in done"}, {63'd0, stall_req}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk({nm, " hold ready"}, {63'd0, ready}, 64'd1);
      chk({nm, " hold result"}, result, exp);
    end
    start = 1'b0;
    cyc();
    chk({nm, " ready clear"}, {63'd0, ready}, 64'd0);
    chk({nm, " result clear"}, result, 64'd0);
  endtask

  vec_t v[10];

  initial begin
    bit seen;
    int n;
    v[0] = '{32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33};
    v[1] = '{32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33};
    v[2] = '{32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 33};
    v[3] = '{32'd5, 32'd0, 1'b0, 64'd0, 2};
    v[4] = '{32'd3, 32'd10, 1'b0, {32'd3, 32'd0}, 33};
    v[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, {32'd0, 32'd1}, 33};
    v[6] = '{32'hFFFFFFF9, 32'd2, 1'b0, {32'd1, 32'h7FFFFFFC}, 33};
`ifdef DIV_SIGNED_EN
    v[7] = '{32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
    v[8] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0, 32'h80000000}, 33};
    v[9] = '{32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, 33};
`else
    v[7] = '{32'hFFFFFFF9, 32'd2, 1'b1, {32'd1, 32'h7FFFFFFC}, 33};
    v[8] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'd0}, 33};
    v[9] = '{32'd7, 32'hFFFFFFFE, 1'b1, {32'd7, 32'd0}, 33};
`endif
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
    #12;
    chk("reset ready", {63'd0, ready}, 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) run_div($sformatf("vec%0d", i), v[i].a, v[i].b, v[i].sd, v[i].exp, v[i].lat, 0);
    // Annul on BUSY cycle 10
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (10) cyc();
    annul = 1'b1;
    #1 chk("annul busy stall", {63'd0, stall_req}, 64'd1);
    cyc();
    chk("annul stall drop", {63'd0, stall_req}, 64'd0);
    chk("annul ready", {63'd0, ready}, 64'd0);
    annul = 1'b0; start = 1'b0; seen = 1'b0;
    repeat (40) begin
      cyc();
      if (ready) seen = 1'b1;
    end
    chk("annul ready never", {63'd0, seen}, 64'd0);
    run_div("after annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 0);
    // Async reset mid-BUSY, between edges
    opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    repeat (20) cyc();
    start = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst busy stall", {63'd0, stall_req}, 64'd0);
    chk("rst busy ready", {63'd0, ready}, 64'd0);
    chk("rst busy result", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div("after rst", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 0);
    // Async reset while DONE holds a nonzero result
    opdata1 = 32'd9; opdata2 = 32'd3; start = 1'b1; n = 0;
    while (!ready && n < 40) begin
      cyc();
      n++;
    end
    chk("done pre-rst result", result, {32'd0, 32'd3});
    #2 rst = 1'b0;
    #1;
    chk("rst done ready", {63'd0, ready}, 64'd0);
    chk("rst done result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    // Handshake: hold start 5 cycles past DONE, then re-raise for a new divide
    run_div("handshake", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 5);
    run_div("reraise", 32'd50, 32'd8, 1'b0, {32'd2, 32'd6}, 33, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
